// File: rtl/logic_alu_seq_pkg.sv
// Shared types for the logic ALU sequencer: op codes, FSM states, op decode helpers.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_SHL = 3'b011,
        OP_SHR = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SHIFT,
        DONE
    } state_t;

    function automatic logic op_legal(input logic [2:0] code);
        return code <= 3'b100;
    endfunction

    function automatic logic op_is_shift(input logic [2:0] code);
        return (code == OP_SHL) || (code == OP_SHR);
    endfunction

endpackage

// File: rtl/logic_alu_seq_step.sv
// Combinational single-step ALU: bitwise logic ops or a one-position zero-fill shift.
module logic_step
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] res,
    output logic         sh_out
);

    always_comb begin
        res    = '0;
        sh_out = 1'b0;
        case (op_t'(op))
            OP_AND: res = x & y;
            OP_OR:  res = x | y;
            OP_XOR: res = x ^ y;
            OP_SHL: begin
                res    = {x[N-2:0], 1'b0};
                sh_out = x[N-1];
            end
            OP_SHR: begin
                res    = {1'b0, x[N-1:1]};
                sh_out = x[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/logic_alu_seq.sv
// Sequencing controller: accepts one request, runs logic ops in one cycle and
// shifts iteratively, then holds result and flags until the consumer drains them.
module logic_alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_err,
    output logic         busy
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [N:0]    N_WIDE  = (N + 1)'(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state, state_nx;
    logic [2:0]    op_r;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [CW-1:0] cnt;
    logic [N-1:0]  result_r;
    logic          z_r, c_r, err_r;
    logic [N-1:0]  step_res;
    logic          step_out;
    logic          accept;

    logic_step #(.N(N)) u_step (
        .op     (op_r),
        .x      (a_r),
        .y      (b_r),
        .res    (step_res),
        .sh_out (step_out)
    );

    assign accept = in_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (op_is_shift(op) && (b != '0)) state_nx = SHIFT;
                    else                              state_nx = RUN;
                end
            end
            RUN:   state_nx = DONE;
            SHIFT: if (cnt == CNT_ONE) state_nx = DONE;
            DONE:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            cnt      <= '0;
            result_r <= '0;
            z_r      <= 1'b0;
            c_r      <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r <= op;
                        a_r  <= a;
                        b_r  <= b;
                        // Amounts of N or more saturate: N steps clear the word.
                        cnt  <= ({1'b0, b} >= N_WIDE) ? CNT_MAX : b[CW-1:0];
                    end
                end
                RUN: begin
                    c_r <= 1'b0;
                    if (!op_legal(op_r)) begin
                        result_r <= '0;
                        z_r      <= 1'b1;
                        err_r    <= 1'b1;
                    end else if (op_is_shift(op_r)) begin
                        result_r <= a_r;
                        z_r      <= (a_r == '0);
                        err_r    <= 1'b0;
                    end else begin
                        result_r <= step_res;
                        z_r      <= (step_res == '0);
                        err_r    <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_r <= step_res;
                    c_r <= step_out;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result_r <= step_res;
                        z_r      <= (step_res == '0);
                        err_r    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = result_r;
    assign flag_z    = z_r;
    assign flag_c    = c_r;
    assign flag_err  = err_r;

endmodule

// File: tb/tb_logic_alu_seq.sv
// Directed-vector bench with a scoreboard queue and an independent output monitor.
module tb_logic_alu_seq;

    typedef struct packed {
        logic [3:0] res;
        logic       z;
        logic       c;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       flag_z, flag_c, flag_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    logic_alu_seq #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_err  (flag_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request; returns #1 after the accept edge (cycle 0).
    task automatic issue(input logic [2:0] o, input logic [3:0] av, input logic [3:0] bv);
        op       = o;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        chk("in_ready_before_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        op       = 3'b000;
        a        = 4'h0;
        b        = 4'h0;
    endtask

    task automatic push(input logic [3:0] r, input logic z, input logic c, input logic e);
        exp_t x;
        x.res = r;
        x.z   = z;
        x.c   = c;
        x.e   = e;
        sb.push_back(x);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk(name, sb.size(), 0);
        step();
    endtask

    // Monitor: every presented-and-accepted output is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got result=%0h with empty scoreboard", result);
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", result, e.res);
                    chk("sb_flag_z", flag_z, e.z);
                    chk("sb_flag_c", flag_c, e.c);
                    chk("sb_flag_err", flag_err, e.e);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        a         = 4'h0;
        b         = 4'h0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_z, flag_c, flag_err}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // AND: one-cycle latency, single-cycle out_valid
        push(4'b1000, 1'b0, 1'b0, 1'b0);
        issue(3'b000, 4'b1100, 4'b1010);
        chk("and_c0_valid", out_valid, 0);
        step();
        chk("and_c1_valid", out_valid, 1);
        step();
        chk("and_c2_valid", out_valid, 0);
        chk("and_c2_in_ready", in_ready, 1);

        // SHL by 2
        push(4'b1100, 1'b0, 1'b0, 1'b0);
        issue(3'b011, 4'b0011, 4'd2);
        chk("shl_c0_busy", busy, 1);
        chk("shl_c0_valid", out_valid, 0);
        step();
        chk("shl_c1_busy", busy, 1);
        chk("shl_c1_valid", out_valid, 0);
        step();
        chk("shl_c2_busy", busy, 1);
        chk("shl_c2_valid", out_valid, 1);
        step();
        chk("shl_c3_busy", busy, 0);

        // SHR by 5 saturates at 4 steps; last bit out is a[3] = 1
        push(4'b0000, 1'b1, 1'b1, 1'b0);
        issue(3'b100, 4'b1011, 4'd5);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("shr_early_valid", out_valid, 0);
        end
        step();
        chk("shr_c4_valid", out_valid, 1);
        step();

        // XOR with back-pressure; a waiting request must not slip in on the drain edge
        out_ready = 1'b0;
        push(4'b0000, 1'b1, 1'b0, 1'b0);
        issue(3'b010, 4'b0110, 4'b0110);
        step();
        op       = 3'b001;
        a        = 4'b0101;
        b        = 4'b0010;
        in_valid = 1'b1;
        push(4'b0111, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            chk("xor_hold_valid", out_valid, 1);
            chk("xor_hold_result", result, 0);
            chk("xor_hold_z", flag_z, 1);
            chk("xor_hold_in_ready", in_ready, 0);
            if (i < 3) step();
        end
        out_ready = 1'b1;
        step();
        chk("xor_drain_valid", out_valid, 0);
        chk("xor_drain_busy", busy, 0);
        chk("xor_drain_in_ready", in_ready, 1);
        step();
        chk("or_accepted_busy", busy, 1);
        in_valid = 1'b0;
        step();
        chk("or_valid", out_valid, 1);
        step();

        // Illegal op, then a legal OR clears err
        push(4'b0000, 1'b1, 1'b0, 1'b1);
        issue(3'b111, 4'hF, 4'h3);
        step();
        chk("ill_valid", out_valid, 1);
        chk("ill_err", flag_err, 1);
        step();
        push(4'b0101, 1'b0, 1'b0, 1'b0);
        issue(3'b001, 4'b0001, 4'b0100);
        step();
        chk("or_err_cleared", flag_err, 0);
        step();

        // Reset during SHIFT discards the request
        issue(3'b011, 4'b0001, 4'd3);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_flags", {flag_z, flag_c, flag_err}, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("postrst_no_valid", out_valid, 0);
        end
        chk("postrst_in_ready", in_ready, 1);
        push(4'b0101, 1'b0, 1'b0, 1'b0);
        issue(3'b000, 4'b1111, 4'b0101);
        wait_drain("postrst_and_drain");

        chk("sb_empty_end", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
